// File: rtl/serial_transmitter_if.sv
// Handshake plus serial link signals between the word source, the transmitter and the
// downstream deserialiser.
interface serial_transmitter_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_clk;
  logic             frame_done;
  logic             busy;

  modport master (
    output data_in, load_valid,
    input  load_ready, ser_out, ser_clk, frame_done, busy
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, ser_out, ser_clk, frame_done, busy
  );
endinterface

// File: rtl/serial_transmitter.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word on a valid/ready handshake and
// shifts it out MSB first with a self-generated bit clock, then idles GAP_CYCLES cycles.
module serial_transmitter #(
  parameter int WIDTH      = 3,
  parameter int HALF_DIV   = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_transmitter_if.slave tx
);

  localparam int DIV_W = $clog2(2 * HALF_DIV);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [DIV_W-1:0] div_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             ser_clk_q;
  logic             frame_done_q;
  logic             busy_q;
  logic             load_ready_q;

  assign shreg_d = shreg_q << 1;

  // The MSB of the shift register is the serial data flop itself; clearing the
  // register at end of frame returns the line to 0.
  assign tx.ser_out    = shreg_q[WIDTH-1];
  assign tx.ser_clk    = ser_clk_q;
  assign tx.frame_done = frame_done_q;
  assign tx.busy       = busy_q;
  assign tx.load_ready = load_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ser_clk_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx.load_valid && load_ready_q) begin
            shreg_q      <= tx.data_in;
            ser_clk_q    <= 1'b1;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (bit_cnt_q != BIT_LAST) begin
              shreg_q   <= shreg_d;
              ser_clk_q <= 1'b1;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end else begin
              shreg_q      <= '0;
              ser_clk_q    <= 1'b0;
              frame_done_q <= 1'b1;
              gap_cnt_q    <= '0;
              if (GAP_CYCLES == 0) begin
                load_ready_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= S_IDLE;
              end else begin
                state_q <= S_GAP;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
            // Single falling edge in the middle of the bit, data held across it.
            if (div_cnt_q == DIV_FALL) begin
              ser_clk_q <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: cycle model keyed on time-since-handshake, a golden
// negedge receiver, directed reset/back-to-back cases and a WIDTH=8 fast-clock instance.
module tb_serial_transmitter;

  localparam int W   = 3;
  localparam int HD  = 2;
  localparam int GAP = 4;
  localparam int F   = W * 2 * HD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_transmitter_if #(.WIDTH(W)) bus ();
  serial_transmitter_if #(.WIDTH(8)) bus8 ();

  serial_transmitter #(.WIDTH(W), .HALF_DIV(HD), .GAP_CYCLES(GAP)) u_dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  serial_transmitter #(.WIDTH(8), .HALF_DIV(1), .GAP_CYCLES(0)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .tx  (bus8)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: t = rising edges since the accepting edge, -1 when idle.
  int         t = -1;
  int         cyc = 0;
  int         hs_count = 0;
  int         hs_prev = 0;
  int         hs_last = 0;
  int         fd_count = 0;
  bit         pre_ready;
  logic [W-1:0] cur_word = '0;
  logic [W-1:0] sent_q[$];
  int         e_out, e_clk, e_fd, e_busy, e_rdy;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      t = -1;
    end else begin
      pre_ready = (t < 0) || (t >= F + GAP);
      if (pre_ready && bus.load_valid) begin
        t        = 0;
        cur_word = bus.data_in;
        sent_q.push_back(bus.data_in);
        hs_count++;
        hs_prev  = hs_last;
        hs_last  = cyc;
      end else if (pre_ready) begin
        t = -1;
      end else begin
        t++;
      end
    end
    #1;
    e_fd   = (t == F) ? 1 : 0;
    e_rdy  = ((t < 0) || (t >= F + GAP)) ? 1 : 0;
    e_busy = 1 - e_rdy;
    if (t >= 0 && t < F) begin
      e_out = int'(cur_word[W - 1 - t / (2 * HD)]);
      e_clk = ((t % (2 * HD)) < HD) ? 1 : 0;
    end else begin
      e_out = 0;
      e_clk = 0;
    end
    check("ser_out",    32'(bus.ser_out),    e_out);
    check("ser_clk",    32'(bus.ser_clk),    e_clk);
    check("frame_done", 32'(bus.frame_done), e_fd);
    check("busy",       32'(bus.busy),       e_busy);
    check("load_ready", 32'(bus.load_ready), e_rdy);
    if (bus.frame_done) fd_count++;
  end

  // Golden deserialiser; reset here stands in for the controller's resync duty.
  int           rx_n = 0;
  int           rx_count = 0;
  logic [W-1:0] rx_sh = '0;
  logic [W-1:0] rx_exp;

  always @(negedge bus.ser_clk or posedge rst) begin
    if (rst) begin
      rx_n = 0;
      sent_q.delete();
    end else begin
      rx_sh = {rx_sh[W-2:0], bus.ser_out};
      rx_n++;
      if (rx_n == W) begin
        rx_n = 0;
        rx_count++;
        if (sent_q.size() == 0) begin
          check("rx_unexpected_word", 32'(rx_sh), 32'hffff_ffff);
        end else begin
          rx_exp = sent_q.pop_front();
          check("rx_word", 32'(rx_sh), 32'(rx_exp));
        end
      end
    end
  end

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (hs_count < target) check("hs_timeout", 32'(hs_count), 32'(target));
  endtask

  initial begin
    int           fd_before;
    int           rx_before;
    int           target;
    int           n;
    logic [7:0]   w8;

    bus.data_in     = '0;
    bus.load_valid  = 1'b0;
    bus8.data_in    = '0;
    bus8.load_valid = 1'b0;

    #2 rst = 1'b1;
    #1;
    check("rst_ser_out",    32'(bus.ser_out),    0);
    check("rst_ser_clk",    32'(bus.ser_clk),    0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_busy",       32'(bus.busy),       0);
    check("rst_load_ready", 32'(bus.load_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single frame 3'b101.
    @(negedge clk);
    bus.data_in    = 3'b101;
    bus.load_valid = 1'b1;
    wait_hs(hs_count + 1);
    bus.load_valid = 1'b0;
    repeat (F + GAP + 3) @(negedge clk);

    // Back-to-back with valid held high.
    bus.data_in    = 3'b110;
    bus.load_valid = 1'b1;
    wait_hs(hs_count + 1);
    bus.data_in    = 3'b011;
    wait_hs(hs_count + 1);
    bus.load_valid = 1'b0;
    check("hs_spacing", 32'(hs_last - hs_prev), 32'(F + GAP + 1));
    repeat (F + GAP + 3) @(negedge clk);

    // Abort frame 3'b111 during its second bit.
    fd_before      = fd_count;
    bus.data_in    = 3'b111;
    bus.load_valid = 1'b1;
    wait_hs(hs_count + 1);
    bus.load_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ser_out",    32'(bus.ser_out),    0);
    check("arst_ser_clk",    32'(bus.ser_clk),    0);
    check("arst_frame_done", 32'(bus.frame_done), 0);
    check("arst_busy",       32'(bus.busy),       0);
    check("arst_load_ready", 32'(bus.load_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_frame_done", 32'(fd_count), 32'(fd_before));

    rx_before      = rx_count;
    bus.data_in    = 3'b010;
    bus.load_valid = 1'b1;
    wait_hs(hs_count + 1);
    bus.load_valid = 1'b0;
    repeat (F + GAP + 3) @(negedge clk);
    check("rx_after_abort", 32'(rx_count), 32'(rx_before + 1));

    // Random traffic; valid and data also wiggle while the frame is in flight.
    target = hs_count + 200;
    n = 0;
    while (hs_count < target && n < 20000) begin
      @(negedge clk);
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.data_in    = W'($urandom);
      n++;
    end
    if (hs_count < target) check("random_hs_timeout", 32'(hs_count), 32'(target));
    bus.load_valid = 1'b0;
    repeat (F + GAP + 5) @(negedge clk);
    check("rx_total",      32'(rx_count),      32'(hs_count - 1));
    check("fd_total",      32'(fd_count),      32'(rx_count));
    check("sent_q_empty",  32'(sent_q.size()), 0);

    // WIDTH=8, HALF_DIV=1, GAP_CYCLES=0 instance.
    w8 = 8'hA5;
    @(negedge clk);
    bus8.data_in    = w8;
    bus8.load_valid = 1'b1;
    check("w8_ready_idle", 32'(bus8.load_ready), 1);
    @(posedge clk);
    #1 bus8.load_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("w8_ser_out",    32'(bus8.ser_out),    32'(w8[7 - k / 2]));
      check("w8_ser_clk",    32'(bus8.ser_clk),    ((k % 2) == 0) ? 32'd1 : 32'd0);
      check("w8_frame_done", 32'(bus8.frame_done), 0);
      @(posedge clk);
      #1;
    end
    check("w8_fd_pulse",     32'(bus8.frame_done), 1);
    check("w8_ser_clk_end",  32'(bus8.ser_clk),    0);
    check("w8_ser_out_end",  32'(bus8.ser_out),    0);
    @(posedge clk);
    #1;
    check("w8_fd_single",    32'(bus8.frame_done), 0);
    check("w8_ready_after",  32'(bus8.load_ready), 1);
    check("w8_busy_after",   32'(bus8.busy),       0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
